// File: rtl/lfsr_sram_ctrl_if.sv
// rtl/lfsr_sram_ctrl_if.sv - LFSR/SRAM controller bus: seed, enables, SRAM read data, strobes, write data and addresses
interface lfsr_sram_ctrl_if #(
    parameter int AW = 7
);
    logic [97:0]   rg_out;
    logic          EN_LFSR;
    logic          EN_LOAD_SRAM;
    logic [63:0]   dataout1;
    logic [63:0]   dataout2;
    logic [63:0]   dataout3;
    logic [63:0]   dataout4;
    logic [63:0]   dataout_ba;
    logic          OEB1;
    logic          CSB1;
    logic          WEB1;
    logic          OEB2;
    logic          CSB2;
    logic          WEB2;
    logic [63:0]   datain1;
    logic [63:0]   datain2;
    logic [63:0]   datain3;
    logic [63:0]   datain4;
    logic [63:0]   datain_ba;
    logic [AW-1:0] address;
    logic [AW-1:0] address_ba;

    modport slave (
        input  rg_out, EN_LFSR, EN_LOAD_SRAM,
        input  dataout1, dataout2, dataout3, dataout4, dataout_ba,
        input  OEB1, CSB1, WEB1, OEB2, CSB2, WEB2,
        output datain1, datain2, datain3, datain4, datain_ba, address, address_ba
    );

    modport master (
        output rg_out, EN_LFSR, EN_LOAD_SRAM,
        output dataout1, dataout2, dataout3, dataout4, dataout_ba,
        output OEB1, CSB1, WEB1, OEB2, CSB2, WEB2,
        input  datain1, datain2, datain3, datain4, datain_ba, address, address_ba
    );
endinterface

// File: rtl/lfsr_sram_ctrl.sv
// rtl/lfsr_sram_ctrl.sv - 98-bit LFSR pattern source with mask preload and SRAM write-data/address generation
module lfsr_sram_ctrl #(
    parameter int TAP = 26,
    parameter int AW  = 7
) (
    input  logic               clk,
    input  logic               reset,
    lfsr_sram_ctrl_if.slave    bus
);
    logic [97:0]   s_q, s_d;
    logic [63:0]   m_q, m_d;
    logic [AW-1:0] a_q, a_d;
    logic [AW-1:0] b_q, b_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s_q <= '0;
            m_q <= '0;
            a_q <= '0;
            b_q <= '0;
        end else begin
            s_q <= s_d;
            m_q <= m_d;
            a_q <= a_d;
            b_q <= b_d;
        end
    end

    always_comb begin
        s_d = s_q;
        m_d = m_q;
        a_d = a_q;
        b_d = b_q;
        case ({bus.EN_LFSR, bus.EN_LOAD_SRAM})
            2'b10: s_d = bus.rg_out;
            2'b01: begin
                if (!bus.CSB2 && !bus.OEB2) begin
                    m_d = bus.dataout_ba;
                    b_d = b_q + 1'b1;
                end
            end
            2'b11: begin
                // An all-zero state stays zero; seeding a non-zero value is left to the user.
                s_d = {s_q[96:0], s_q[97] ^ s_q[TAP]};
                if (!bus.CSB1 && !bus.WEB1) begin
                    a_d = a_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Write data reflects the pre-step state, so the word landing at address A comes from the old S.
    assign bus.datain1    = s_q[63:0] ^ m_q;
    assign bus.datain2    = {30'b0, s_q[97:64]};
    assign bus.datain3    = bus.dataout3 ^ s_q[63:0];
    assign bus.datain4    = bus.dataout4 ^ {30'b0, s_q[97:64]};
    assign bus.datain_ba  = m_q;
    assign bus.address    = a_q;
    assign bus.address_ba = b_q;

    logic unused_inputs;
    assign unused_inputs = ^{bus.dataout1, bus.dataout2, bus.OEB1, bus.WEB2};
endmodule

// File: tb/tb_lfsr_sram_ctrl.sv
// tb/tb_lfsr_sram_ctrl.sv - directed scoreboard bench for lfsr_sram_ctrl
module tb_lfsr_sram_ctrl;
    logic clk = 1'b0;
    logic reset;

    lfsr_sram_ctrl_if bus ();

    lfsr_sram_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [63:0] val;
    } exp_t;

    exp_t        sb[$];
    int          checks   = 0;
    int          failures = 0;
    logic [97:0] ms;
    logic [63:0] mm;
    logic [6:0]  ma;
    logic [6:0]  mb;

    task automatic expect_v(input string tag, input logic [63:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic check_v(input string tag, input logic [63:0] obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $error("FAIL %s scoreboard empty observed=%h", tag, obs);
            return;
        end
        e = sb.pop_front();
        assert (obs === e.val && tag == e.tag) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h (expected tag %s)", tag, obs, e.val, e.tag);
        end
    endtask

    task automatic expect_model();
        expect_v("datain1", ms[63:0] ^ mm);
        expect_v("datain2", {30'b0, ms[97:64]});
        expect_v("datain3", bus.dataout3 ^ ms[63:0]);
        expect_v("datain4", bus.dataout4 ^ {30'b0, ms[97:64]});
        expect_v("datain_ba", mm);
        expect_v("address", {57'b0, ma});
        expect_v("address_ba", {57'b0, mb});
    endtask

    task automatic check_all();
        check_v("datain1", bus.datain1);
        check_v("datain2", bus.datain2);
        check_v("datain3", bus.datain3);
        check_v("datain4", bus.datain4);
        check_v("datain_ba", bus.datain_ba);
        check_v("address", {57'b0, bus.address});
        check_v("address_ba", {57'b0, bus.address_ba});
    endtask

    task automatic check_zero_state();
        expect_v("datain1", 64'h0);
        expect_v("datain2", 64'h0);
        expect_v("datain3", bus.dataout3);
        expect_v("datain4", bus.dataout4);
        expect_v("datain_ba", 64'h0);
        expect_v("address", 64'h0);
        expect_v("address_ba", 64'h0);
        check_all();
    endtask

    task automatic model_step();
        case ({bus.EN_LFSR, bus.EN_LOAD_SRAM})
            2'b10: ms = bus.rg_out;
            2'b01: if (!bus.CSB2 && !bus.OEB2) begin
                mm = bus.dataout_ba;
                mb = mb + 7'd1;
            end
            2'b11: begin
                ms = {ms[96:0], ms[97] ^ ms[26]};
                if (!bus.CSB1 && !bus.WEB1) ma = ma + 7'd1;
            end
            default: ;
        endcase
    endtask

    task automatic clk_edge();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [127:0] r;
        reset            = 1'b1;
        bus.rg_out       = '0;
        bus.EN_LFSR      = 1'b0;
        bus.EN_LOAD_SRAM = 1'b0;
        bus.dataout1     = 64'h0;
        bus.dataout2     = 64'h0;
        bus.dataout3     = 64'h1234_5678_9abc_def0;
        bus.dataout4     = 64'h0fed_cba9_8765_4321;
        bus.dataout_ba   = 64'h0;
        bus.OEB1         = 1'b1;
        bus.CSB1         = 1'b1;
        bus.WEB1         = 1'b1;
        bus.OEB2         = 1'b1;
        bus.CSB2         = 1'b1;
        bus.WEB2         = 1'b1;
        ms = '0; mm = '0; ma = '0; mb = '0;

        #1;
        check_zero_state();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Seed
        bus.EN_LFSR = 1'b1;
        bus.rg_out  = 98'h0_0002_8002_c000_6c6c_0000_0000;
        clk_edge();
        expect_v("datain1", 64'hc000_6c6c_0000_0000);
        check_v("datain1", bus.datain1);
        expect_v("datain2", 64'h0000_0000_0002_8002);
        check_v("datain2", bus.datain2);

        // One write-shift step with a group-1 write
        bus.EN_LOAD_SRAM = 1'b1;
        bus.CSB1 = 1'b0;
        bus.WEB1 = 1'b0;
        clk_edge();
        expect_v("datain1", 64'h8000_d8d8_0000_0000);
        check_v("datain1", bus.datain1);
        expect_v("datain2", 64'h0000_0000_0005_0005);
        check_v("datain2", bus.datain2);
        expect_v("address", 64'd1);
        check_v("address", {57'b0, bus.address});
        expect_model();
        check_all();

        // Preload mask
        bus.EN_LFSR    = 1'b0;
        bus.CSB1       = 1'b1;
        bus.WEB1       = 1'b1;
        bus.CSB2       = 1'b0;
        bus.OEB2       = 1'b0;
        bus.dataout_ba = 64'hFFFF_0000_FFFF_0000;
        clk_edge();
        expect_v("datain_ba", 64'hFFFF_0000_FFFF_0000);
        check_v("datain_ba", bus.datain_ba);
        expect_v("address_ba", 64'd1);
        check_v("address_ba", {57'b0, bus.address_ba});
        expect_v("datain1", 64'h8000_d8d8_0000_0000 ^ 64'hFFFF_0000_FFFF_0000);
        check_v("datain1", bus.datain1);
        expect_model();
        check_all();

        // Preload blocked by OEB2
        bus.OEB2       = 1'b1;
        bus.dataout_ba = 64'h1111_2222_3333_4444;
        clk_edge();
        expect_v("datain_ba", 64'hFFFF_0000_FFFF_0000);
        check_v("datain_ba", bus.datain_ba);
        expect_model();
        check_all();

        // Reset asserted mid write-shift clears without a clock edge
        bus.EN_LFSR = 1'b1;
        bus.CSB1    = 1'b0;
        bus.WEB1    = 1'b0;
        bus.CSB2    = 1'b1;
        clk_edge();
        expect_model();
        check_all();
        #2 reset = 1'b1;
        #1;
        check_zero_state();
        ms = '0; mm = '0; ma = '0; mb = '0;
        @(negedge clk);
        reset = 1'b0;

        // Random non-zero seed
        r = {$urandom(), $urandom(), $urandom(), $urandom()};
        bus.rg_out       = r[97:0] | 98'd1;
        bus.EN_LFSR      = 1'b1;
        bus.EN_LOAD_SRAM = 1'b0;
        clk_edge();
        expect_model();
        check_all();

        // 128 write-shift edges: address wraps to 0
        bus.EN_LOAD_SRAM = 1'b1;
        for (int i = 0; i < 128; i++) begin
            clk_edge();
            if (i == 126) begin
                expect_v("address", 64'd127);
                check_v("address", {57'b0, bus.address});
            end
            expect_model();
            check_all();
        end
        expect_v("address", 64'd0);
        check_v("address", {57'b0, bus.address});

        // WEB1 high: S steps, address holds
        bus.WEB1 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            clk_edge();
            expect_v("address", 64'd0);
            check_v("address", {57'b0, bus.address});
            expect_model();
            check_all();
        end

        // IDLE
        bus.EN_LFSR      = 1'b0;
        bus.EN_LOAD_SRAM = 1'b0;
        bus.rg_out       = '0;
        for (int i = 0; i < 10; i++) begin
            clk_edge();
            expect_model();
            check_all();
        end

        // datain3/datain4 follow dataout3/dataout4 combinationally
        #2;
        bus.dataout3 = 64'hdead_beef_cafe_f00d;
        bus.dataout4 = 64'h0000_0003_ffff_ffff;
        #1;
        expect_v("datain3", 64'hdead_beef_cafe_f00d ^ ms[63:0]);
        check_v("datain3", bus.datain3);
        expect_v("datain4", 64'h0000_0003_ffff_ffff ^ {30'b0, ms[97:64]});
        check_v("datain4", bus.datain4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
